// File: rtl/fork_join_pkg.sv
// rtl/fork_join_pkg.sv - shared state encoding and default widths for fork/join blocks
package fork_join_pkg;

    localparam int FJ_DATA_WIDTH_O0 = 18;
    localparam int FJ_DATA_WIDTH_O1 = 32;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY
    } fork_state_t;

endpackage

// File: rtl/branch_free_tracker.sv
// rtl/branch_free_tracker.sv - per-branch done flag, stray free detect and last-free indicator
module branch_free_tracker (
    input  logic clk,
    input  logic rstn,
    input  logic busy,
    input  logic free_in,
    input  logic clear,
    output logic done,
    output logic stray,
    output logic last
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done <= 1'b0;
        end else if (clear) begin
            done <= 1'b0;
        end else if (busy && free_in) begin
            done <= 1'b1;
        end
    end

    // A free is stray when no token is outstanding or this branch already freed it
    assign stray = free_in && (!busy || done);
    assign last  = busy && (done || free_in);

endmodule

// File: rtl/sync_fork_split2.sv
// rtl/sync_fork_split2.sv - two-way drive/free fork; FORK_PENDING_BUF_EN adds a one-entry pending token
module sync_fork_split2
    import fork_join_pkg::*;
#(
    parameter int DATA_WIDTH_O0 = FJ_DATA_WIDTH_O0,
    parameter int DATA_WIDTH_O1 = FJ_DATA_WIDTH_O1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 i_drive,
    input  logic [DATA_WIDTH_O0+DATA_WIDTH_O1-1:0] i_data,
    output logic                                 o_free,
    output logic                                 o_drive0,
    output logic [DATA_WIDTH_O0-1:0]             o_data0,
    input  logic                                 i_free0,
    output logic                                 o_drive1,
    output logic [DATA_WIDTH_O1-1:0]             o_data1,
    input  logic                                 i_free1,
    output logic                                 o_busy,
    output logic                                 o_overrun,
    output logic                                 o_stray
);

    localparam int W = DATA_WIDTH_O0 + DATA_WIDTH_O1;

    fork_state_t state, state_n;
    logic        drive_n, free_n, overrun_n, stray_n;
    logic [DATA_WIDTH_O0-1:0] data0_n;
    logic [DATA_WIDTH_O1-1:0] data1_n;
    logic        done0, done1, stray0, stray1, last0, last1;
    logic        busy, complete;

    assign busy     = (state == S_BUSY);
    assign complete = last0 && last1;

    branch_free_tracker u_trk0 (
        .clk(clk), .rstn(rstn), .busy(busy), .free_in(i_free0), .clear(complete),
        .done(done0), .stray(stray0), .last(last0)
    );

    branch_free_tracker u_trk1 (
        .clk(clk), .rstn(rstn), .busy(busy), .free_in(i_free1), .clear(complete),
        .done(done1), .stray(stray1), .last(last1)
    );

`ifdef FORK_PENDING_BUF_EN
    logic         pend_valid, pend_valid_n;
    logic [W-1:0] pend_data, pend_data_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            pend_valid <= pend_valid_n;
            pend_data  <= pend_data_n;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            o_drive0  <= 1'b0;
            o_drive1  <= 1'b0;
            o_free    <= 1'b0;
            o_data0   <= '0;
            o_data1   <= '0;
            o_overrun <= 1'b0;
            o_stray   <= 1'b0;
        end else begin
            state     <= state_n;
            o_drive0  <= drive_n;
            o_drive1  <= drive_n;
            o_free    <= free_n;
            o_data0   <= data0_n;
            o_data1   <= data1_n;
            o_overrun <= overrun_n;
            o_stray   <= stray_n;
        end
    end

    assign o_busy = busy;

    always_comb begin
        state_n   = state;
        drive_n   = 1'b0;
        free_n    = 1'b0;
        data0_n   = o_data0;
        data1_n   = o_data1;
        overrun_n = o_overrun;
        stray_n   = o_stray || stray0 || stray1;
`ifdef FORK_PENDING_BUF_EN
        pend_valid_n = pend_valid;
        pend_data_n  = pend_data;
        case (state)
            S_IDLE: begin
                // Pending can only be valid here right after a completion that captured a token
                if (pend_valid) begin
                    drive_n      = 1'b1;
                    {data1_n, data0_n} = pend_data;
                    state_n      = S_BUSY;
                    pend_valid_n = i_drive;
                    if (i_drive) pend_data_n = i_data;
                end else if (i_drive) begin
                    drive_n = 1'b1;
                    {data1_n, data0_n} = i_data;
                    state_n = S_BUSY;
                end
            end
            default: begin
                if (complete) begin
                    free_n = 1'b1;
                    if (pend_valid) begin
                        drive_n      = 1'b1;
                        {data1_n, data0_n} = pend_data;
                        pend_valid_n = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                if (i_drive) begin
                    if (pend_valid) begin
                        overrun_n = 1'b1;
                    end else begin
                        pend_valid_n = 1'b1;
                        pend_data_n  = i_data;
                    end
                end
            end
        endcase
`else
        case (state)
            S_IDLE: begin
                if (i_drive) begin
                    drive_n = 1'b1;
                    {data1_n, data0_n} = i_data;
                    state_n = S_BUSY;
                end
            end
            default: begin
                if (complete) begin
                    free_n  = 1'b1;
                    state_n = S_IDLE;
                end
                // No storage: any drive while a token is outstanding is lost
                if (i_drive) overrun_n = 1'b1;
            end
        endcase
`endif
    end

endmodule

// File: tb/tb_sync_fork_split2.sv
// tb/tb_sync_fork_split2.sv - scoreboard bench for sync_fork_split2
module tb_sync_fork_split2;

    localparam int W0 = 18;
    localparam int W1 = 32;
    localparam int W  = W0 + W1;

    typedef struct {
        int           cyc;
        logic [W-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_drive = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic          o_free, o_drive0, o_drive1, o_busy, o_overrun, o_stray;
    logic [W0-1:0] o_data0;
    logic [W1-1:0] o_data1;
    logic          i_free0 = 1'b0;
    logic          i_free1 = 1'b0;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t drive_q[$];
    exp_t free_q[$];

    sync_fork_split2 #(.DATA_WIDTH_O0(W0), .DATA_WIDTH_O1(W1)) dut (
        .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data),
        .o_free(o_free), .o_drive0(o_drive0), .o_data0(o_data0), .i_free0(i_free0),
        .o_drive1(o_drive1), .o_data1(o_data1), .i_free1(i_free1),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_stray(o_stray)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every drive/free pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rstn) begin
            if (o_drive0 || o_drive1) begin
                exp_t e;
                check("drive_pair", {62'd0, o_drive0, o_drive1}, 64'h3);
                if (drive_q.size() == 0) begin
                    check("drive_unexpected", 64'd1, 64'd0);
                end else begin
                    e = drive_q.pop_front();
                    check("drive_cycle", 64'(cyc), 64'(e.cyc));
                    check("drive_data0", 64'(o_data0), 64'(e.d[W0-1:0]));
                    check("drive_data1", 64'(o_data1), 64'(e.d[W-1:W0]));
                end
            end
            if (o_free) begin
                exp_t e;
                if (free_q.size() == 0) begin
                    check("free_unexpected", 64'd1, 64'd0);
                end else begin
                    e = free_q.pop_front();
                    check("free_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ticks(2);
        rstn = 1'b1;
        tick();
    endtask

    task automatic send(input logic [W-1:0] d, input bit launch);
        exp_t e;
        i_drive = 1'b1;
        i_data  = d;
        if (launch) begin
            e.cyc = cyc + 1;
            e.d   = d;
            drive_q.push_back(e);
        end
        tick();
        i_drive = 1'b0;
    endtask

    task automatic free(input bit f0, input bit f1, input bit expect_free);
        exp_t e;
        i_free0 = f0;
        i_free1 = f1;
        if (expect_free) begin
            e.cyc = cyc + 1;
            e.d   = '0;
            free_q.push_back(e);
        end
        tick();
        i_free0 = 1'b0;
        i_free1 = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a, b, c, d, f;
        a = {32'hDEADBEEF, 18'h2A5A5};
        b = {32'h12345678, 18'h00001};
        c = {32'hCAFEF00D, 18'h3FFFF};
        d = {32'h0BADC0DE, 18'h15555};
        f = {32'hFFFFFFFF, 18'h20000};

        ticks(2);
        check("reset_outputs", {58'd0, o_free, o_drive0, o_drive1, o_busy, o_overrun, o_stray}, 64'd0);
        check("reset_data", {14'd0, o_data1, o_data0}, 64'd0);
        rstn = 1'b1;
        tick();

        // Launch, then staggered frees
        send(a, 1'b1);
        check("busy_after_launch", 64'(o_busy), 64'd1);
        check("data0_held", 64'(o_data0), 64'h2A5A5);
        check("data1_held", 64'(o_data1), 64'hDEADBEEF);
        ticks(2);
        free(1'b1, 1'b0, 1'b0);
        ticks(3);
        check("busy_before_last_free", 64'(o_busy), 64'd1);
        free(1'b0, 1'b1, 1'b1);
        check("busy_falls_with_free", 64'(o_busy), 64'd0);
        check("free_pulse_visible", 64'(o_free), 64'd1);
        tick();

        // Simultaneous frees
        send(b, 1'b1);
        free(1'b1, 1'b1, 1'b1);
        tick();
        check("no_stray_simultaneous", 64'(o_stray), 64'd0);
        check("idle_after_simultaneous", 64'(o_busy), 64'd0);

        // Drive while busy
        send(c, 1'b1);
        free(1'b1, 1'b0, 1'b0);
`ifdef FORK_PENDING_BUF_EN
        send(d, 1'b0);
        check("no_overrun_pending", 64'(o_overrun), 64'd0);
        begin
            exp_t e;
            e.cyc = cyc + 1;
            e.d   = d;
            drive_q.push_back(e);
        end
        free(1'b0, 1'b1, 1'b1);
        check("relaunch_busy", 64'(o_busy), 64'd1);
        ticks(1);
        free(1'b1, 1'b1, 1'b1);
`else
        send(d, 1'b0);
        check("overrun_set", 64'(o_overrun), 64'd1);
        check("data0_unchanged", 64'(o_data0), 64'(c[W0-1:0]));
        check("data1_unchanged", 64'(o_data1), 64'(c[W-1:W0]));
        free(1'b0, 1'b1, 1'b1);
`endif
        tick();
        check("idle_after_overrun_test", 64'(o_busy), 64'd0);

        // Stray in IDLE
        do_reset();
        check("overrun_cleared_by_reset", 64'(o_overrun), 64'd0);
        free(1'b1, 1'b0, 1'b0);
        tick();
        check("stray_idle", 64'(o_stray), 64'd1);

        // Double free1 while busy; completion timing unaffected
        do_reset();
        check("stray_cleared_by_reset", 64'(o_stray), 64'd0);
        send(a, 1'b1);
        free(1'b0, 1'b1, 1'b0);
        free(1'b0, 1'b1, 1'b0);
        check("stray_double_free", 64'(o_stray), 64'd1);
        check("busy_after_stray", 64'(o_busy), 64'd1);
        free(1'b1, 1'b0, 1'b1);
        tick();

        // Async reset mid-token, then a late free
        send(f, 1'b1);
        ticks(1);
        rstn = 1'b0;
        #1;
        check("async_reset_busy", 64'(o_busy), 64'd0);
        check("async_reset_data", {14'd0, o_data1, o_data0}, 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        free(1'b0, 1'b1, 1'b0);
        ticks(3);
        check("late_free_stray", 64'(o_stray), 64'd1);
        check("late_free_idle", 64'(o_busy), 64'd0);

        check("drive_queue_drained", 64'(drive_q.size()), 64'd0);
        check("free_queue_drained", 64'(free_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
